// File: rtl/cipher_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cipher_stream_ctrl
// Brief    : Byte-stream front end for a block-cipher core (keys/IV/data
//            assembly, ECB/CBC chaining, start/done handshake, byte output).
// Revision : 1.0 - initial release
// ============================================================================
module cipher_stream_ctrl #(
    parameter int BLOCK_BYTES = 8,
    parameter int NUM_KEYS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stop,
    input  logic                        rw_mode,
    input  logic                        cbc_en,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        eng_start,
    output logic                        eng_decrypt,
    output logic [8*BLOCK_BYTES-1:0]    eng_din,
    output logic [NUM_KEYS*8*BLOCK_BYTES-1:0] eng_keys,
    input  logic [8*BLOCK_BYTES-1:0]    eng_dout,
    input  logic                        eng_done,
    output logic                        keys_loaded,
    output logic                        busy
);

    localparam int W     = 8 * BLOCK_BYTES;
    localparam int CNT_W = $clog2(BLOCK_BYTES);
    localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [KEY_W-1:0] c_last_key  = KEY_W'(NUM_KEYS - 1);

    localparam logic [2:0] c_st_load_key = 3'd0;
    localparam logic [2:0] c_st_load_iv  = 3'd1;
    localparam logic [2:0] c_st_collect  = 3'd2;
    localparam logic [2:0] c_st_crypt    = 3'd3;
    localparam logic [2:0] c_st_emit     = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [KEY_W-1:0]    key_idx_q, key_idx_d;
    logic [NUM_KEYS*W-1:0] keys_q, keys_d;
    logic [W-1:0]        chain_q, chain_d;
    logic [W-1:0]        shift_q, shift_d;
    logic [W-1:0]        blk_q, blk_d;
    logic [W-1:0]        res_q, res_d;
    logic                start_q, start_d;
    logic                keys_loaded_q, keys_loaded_d;
    logic                dec_q, dec_d;
    logic                cbc_q, cbc_d;
    logic                stop_pend_q, stop_pend_d;

    logic                w_load_state;
    logic                w_accept;
    logic                w_blk_last;
    logic [W-1:0]        w_block;

    assign w_load_state = (state_q == c_st_load_key) || (state_q == c_st_load_iv) ||
                          (state_q == c_st_collect);
    // stop wins over a same-cycle byte, so the byte is refused outright
    assign in_ready   = w_load_state && !stop;
    assign w_accept   = in_valid && in_ready;
    assign w_blk_last = (byte_cnt_q == c_last_byte);
    assign w_block    = {shift_q[W-9:0], in_byte};

    assign busy        = (state_q == c_st_crypt) || (state_q == c_st_emit);
    assign out_valid   = (state_q == c_st_emit);
    assign out_byte    = res_q[W-1 -: 8];
    assign eng_start   = start_q;
    assign eng_decrypt = dec_q;
    assign eng_keys    = keys_q;
    assign keys_loaded = keys_loaded_q;
    assign eng_din     = (cbc_q && !dec_q) ? (blk_q ^ chain_q) : blk_q;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        out_cnt_d     = out_cnt_q;
        key_idx_d     = key_idx_q;
        keys_d        = keys_q;
        chain_d       = chain_q;
        shift_d       = shift_q;
        blk_d         = blk_q;
        res_d         = res_q;
        start_d       = 1'b0;
        keys_loaded_d = keys_loaded_q;
        dec_d         = dec_q;
        cbc_d         = cbc_q;
        stop_pend_d   = stop_pend_q;

        if (w_load_state && stop) begin
            byte_cnt_d    = '0;
            key_idx_d     = '0;
            keys_loaded_d = 1'b0;
            state_d       = c_st_load_key;
        end else if (w_accept) begin
            shift_d    = w_block;
            byte_cnt_d = w_blk_last ? '0 : byte_cnt_q + CNT_W'(1);
            if ((state_q == c_st_load_key) && (key_idx_q == '0) && (byte_cnt_q == '0)) begin
                dec_d = rw_mode;
                cbc_d = cbc_en;
            end
            if (w_blk_last) begin
                case (state_q)
                    c_st_load_key: begin
                        for (int k = 0; k < NUM_KEYS; k++) begin
                            if (key_idx_q == KEY_W'(k)) keys_d[k*W +: W] = w_block;
                        end
                        if (key_idx_q == c_last_key) begin
                            key_idx_d     = '0;
                            keys_loaded_d = 1'b1;
                            state_d       = cbc_q ? c_st_load_iv : c_st_collect;
                        end else begin
                            key_idx_d = key_idx_q + KEY_W'(1);
                        end
                    end
                    c_st_load_iv: begin
                        chain_d = w_block;
                        state_d = c_st_collect;
                    end
                    default: begin
                        blk_d   = w_block;
                        start_d = 1'b1;
                        state_d = c_st_crypt;
                    end
                endcase
            end
        end

        if (state_q == c_st_crypt) begin
            if (stop) stop_pend_d = 1'b1;
            if (eng_done) begin
                state_d   = c_st_emit;
                out_cnt_d = '0;
                res_d     = eng_dout;
                if (cbc_q && dec_q) begin
                    res_d   = eng_dout ^ chain_q;
                    chain_d = blk_q;
                end else if (cbc_q) begin
                    chain_d = eng_dout;
                end
            end
        end

        if (state_q == c_st_emit) begin
            if (stop) stop_pend_d = 1'b1;
            if (out_ready) begin
                res_d     = {res_q[W-9:0], 8'h00};
                out_cnt_d = out_cnt_q + CNT_W'(1);
                if (out_cnt_q == c_last_byte) begin
                    out_cnt_d = '0;
                    // a stop seen during the block ends the transaction once drained
                    if (stop_pend_q || stop) begin
                        state_d       = c_st_load_key;
                        byte_cnt_d    = '0;
                        key_idx_d     = '0;
                        keys_loaded_d = 1'b0;
                        stop_pend_d   = 1'b0;
                    end else begin
                        state_d = c_st_collect;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= c_st_load_key;
            byte_cnt_q    <= '0;
            out_cnt_q     <= '0;
            key_idx_q     <= '0;
            keys_q        <= '0;
            chain_q       <= '0;
            shift_q       <= '0;
            blk_q         <= '0;
            res_q         <= '0;
            start_q       <= 1'b0;
            keys_loaded_q <= 1'b0;
            dec_q         <= 1'b0;
            cbc_q         <= 1'b0;
            stop_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            out_cnt_q     <= out_cnt_d;
            key_idx_q     <= key_idx_d;
            keys_q        <= keys_d;
            chain_q       <= chain_d;
            shift_q       <= shift_d;
            blk_q         <= blk_d;
            res_q         <= res_d;
            start_q       <= start_d;
            keys_loaded_q <= keys_loaded_d;
            dec_q         <= dec_d;
            cbc_q         <= cbc_d;
            stop_pend_q   <= stop_pend_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cipher_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_stream_ctrl
// Brief    : Scoreboard bench for cipher_stream_ctrl with an XOR-key0 core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, stop, rw_mode, cbc_en, in_valid, out_ready;
    logic [7:0]  in_byte;
    logic        in_ready, out_valid, eng_start, eng_decrypt, keys_loaded, busy;
    logic [7:0]  out_byte;
    logic [63:0] eng_din, eng_dout;
    logic [127:0] eng_keys;
    logic        done_m, done_tb, eng_done_w;

    logic        stop16, in_valid16, out_ready16, eng_done16;
    logic [7:0]  in_byte16, out_byte16;
    logic        in_ready16, out_valid16, eng_start16, eng_decrypt16, keys_loaded16, busy16;
    logic [127:0] eng_din16, eng_dout16;
    logic [383:0] eng_keys16;

    logic [63:0] key0_m, dsample;
    logic [63:0] exp_din_q[$];
    logic [7:0]  exp_out_q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] K0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] K1  = 64'hFEDCBA9876543210;
    localparam logic [63:0] NK0 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] NK1 = 64'h8877665544332211;
    localparam logic [63:0] IV  = 64'hA5A5A5A5A5A5A5A5;

    always #5 clk = ~clk;
    assign eng_done_w = done_m | done_tb;

    cipher_stream_ctrl dut (
        .clk(clk), .rst(rst), .stop(stop), .rw_mode(rw_mode), .cbc_en(cbc_en),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .eng_start(eng_start), .eng_decrypt(eng_decrypt), .eng_din(eng_din),
        .eng_keys(eng_keys), .eng_dout(eng_dout), .eng_done(eng_done_w),
        .keys_loaded(keys_loaded), .busy(busy)
    );

    cipher_stream_ctrl #(.BLOCK_BYTES(16), .NUM_KEYS(3)) dut16 (
        .clk(clk), .rst(rst), .stop(stop16), .rw_mode(rw_mode), .cbc_en(cbc_en),
        .in_byte(in_byte16), .in_valid(in_valid16), .in_ready(in_ready16),
        .out_byte(out_byte16), .out_valid(out_valid16), .out_ready(out_ready16),
        .eng_start(eng_start16), .eng_decrypt(eng_decrypt16), .eng_din(eng_din16),
        .eng_keys(eng_keys16), .eng_dout(eng_dout16), .eng_done(eng_done16),
        .keys_loaded(keys_loaded16), .busy(busy16)
    );

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Core model: result = din ^ key0, done three cycles after start
    initial begin
        done_m   = 1'b0;
        eng_dout = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                dsample = eng_din;
                if (exp_din_q.size() == 0) fail("eng_din_unexpected", dsample);
                else check("eng_din", dsample, exp_din_q.pop_front());
                repeat (3) @(posedge clk);
                #1;
                eng_dout = dsample ^ key0_m;
                done_m   = 1'b1;
                @(posedge clk);
                #1;
                done_m = 1'b0;
            end
        end
    end

    // Monitor: every output transfer pops one expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_out_q.size() == 0) fail("out_unexpected", {56'h0, out_byte});
                else check("out_byte", out_byte, exp_out_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("in_ready_timeout", {56'h0, b});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] v);
        for (int i = 0; i < 8; i++) send_byte(v[63-8*i -: 8]);
    endtask

    task automatic send_data(input logic [63:0] v, input logic [63:0] din, input logic [63:0] res);
        exp_din_q.push_back(din);
        for (int i = 0; i < 8; i++) exp_out_q.push_back(res[63-8*i -: 8]);
        send_block(v);
        @(negedge clk);
        check("start_latency", eng_start, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_out_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", (exp_out_q.size() != 0) || busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic pulse_stop(input logic with_byte);
        stop     = 1'b1;
        in_valid = with_byte;
        in_byte  = 8'hEE;
        @(negedge clk);
        check("stop_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        stop     = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [63:0] pt [3];
    logic [63:0] ct [3];
    logic [63:0] prev, din;

    initial begin
        rst = 1'b1; stop = 1'b0; rw_mode = 1'b0; cbc_en = 1'b0;
        in_valid = 1'b0; in_byte = '0; out_ready = 1'b1; done_tb = 1'b0;
        stop16 = 1'b0; in_valid16 = 1'b0; in_byte16 = '0; out_ready16 = 1'b1;
        eng_done16 = 1'b0; eng_dout16 = '0;
        key0_m = K0;
        pt[0] = 64'h0011223344556677;
        pt[1] = 64'h8899AABBCCDDEEFF;
        pt[2] = 64'h1122334455667788;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_keys_loaded", keys_loaded, 0);
        check("rst_busy", busy, 0);
        check("rst_out_byte", out_byte, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ECB encrypt, hand-computed result
        send_block(K0);
        check("keys_loaded_k0", keys_loaded, 0);
        send_block(K1);
        check("keys_loaded_k1", keys_loaded, 1);
        check("eng_keys", eng_keys, {K1, K0});
        send_data(64'h1111111111111111, 64'h1111111111111111, 64'h1032547698BADCFE);
        check("crypt_in_ready", in_ready, 0);
        check("crypt_busy", busy, 1);
        wait_drain();

        // CBC encrypt, three blocks
        pulse_stop(1'b0);
        cbc_en = 1'b1;
        send_block(K0); send_block(K1); send_block(IV);
        prev = IV;
        for (int i = 0; i < 3; i++) begin
            din   = pt[i] ^ prev;
            ct[i] = din ^ K0;
            send_data(pt[i], din, ct[i]);
            prev = ct[i];
        end
        wait_drain();

        // CBC decrypt of those ciphertexts returns the plaintexts
        pulse_stop(1'b0);
        rw_mode = 1'b1;
        send_block(K0); send_block(K1); send_block(IV);
        for (int i = 0; i < 3; i++) send_data(ct[i], ct[i], pt[i]);
        wait_drain();

        // Backpressure mid-EMIT
        pulse_stop(1'b0);
        rw_mode = 1'b0; cbc_en = 1'b0;
        send_block(K0); send_block(K1);
        send_data(64'h2222222222222222, 64'h2222222222222222, 64'h23016745AB89EFCD);
        wait_out_valid();
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_byte", out_byte, 8'h45);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // stop mid data block, with a same-cycle byte that must be refused
        for (int i = 0; i < 5; i++) send_byte(8'h33);
        pulse_stop(1'b1);
        check("stop_keys_loaded", keys_loaded, 0);
        key0_m = NK0;
        send_block(NK0);
        check("reload_keys_loaded_k0", keys_loaded, 0);
        send_block(NK1);
        check("reload_keys_loaded_k1", keys_loaded, 1);
        check("reload_eng_keys", eng_keys, {NK1, NK0});
        send_data(64'h4444444444444444, 64'h4444444444444444, 64'h4B5A69780F1E2D3C);
        wait_drain();

        // stop during CRYPT: block still drains fully, then key loading
        send_data(64'h5555555555555555, 64'h5555555555555555, 64'h5A4B78691E0F3C2D);
        @(posedge clk);
        #1;
        pulse_stop(1'b0);
        wait_drain();
        check("post_stop_in_ready", in_ready, 1);
        check("post_stop_busy", busy, 0);

        // rst during EMIT after three bytes
        key0_m = K0;
        send_block(K0); send_block(K1);
        send_data(64'h1111111111111111, 64'h1111111111111111, 64'h1032547698BADCFE);
        wait_out_valid();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b0;
        exp_out_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_emit_out_valid", out_valid, 0);
        check("rst_emit_in_ready", in_ready, 1);
        check("rst_emit_busy", busy, 0);
        check("rst_emit_keys_loaded", keys_loaded, 0);
        @(posedge clk);
        #1;
        done_tb = 1'b1;
        @(posedge clk);
        #1;
        done_tb = 1'b0;
        @(negedge clk);
        check("stray_done_out_valid", out_valid, 0);
        check("stray_done_busy", busy, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // 16-byte blocks, three keys: packing offsets
        for (int j = 0; j < 48; j++) begin
            in_byte16  = 8'(j);
            in_valid16 = 1'b1;
            @(posedge clk);
            #1;
            if (j == 46) check("k16_keys_loaded_early", keys_loaded16, 0);
        end
        in_valid16 = 1'b0;
        check("k16_keys_loaded", keys_loaded16, 1);
        check("k16_eng_keys", eng_keys16,
              {128'h202122232425262728292A2B2C2D2E2F,
               128'h101112131415161718191A1B1C1D1E1F,
               128'h000102030405060708090A0B0C0D0E0F});
        check("k16_in_ready", in_ready16, 1);
        check("k16_busy", busy16, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cipher_stream_ctrl.md
Name: cipher_stream_ctrl

Overview:
Parametrised byte-stream front end for a block-cipher engine, the next generation of the I2C DES encryptor top level. It assembles serial bytes into key, IV and data blocks and drives an external cipher core through a start/done handshake. It serialises results back to bytes over valid/ready. Unlike the fixed 64-bit two-key ECB predecessor, it adds configurable block width, configurable key count and CBC chaining.

Parameters:
BLOCK_BYTES, 8, bytes per block; block width W = 8*BLOCK_BYTES (2..16)
NUM_KEYS, 2, key blocks loaded at the start of each transaction (1..4)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
stop  in  1  end-of-transaction pulse from bus controller
rw_mode  in  1  0 = encrypt, 1 = decrypt; latched per transaction
cbc_en  in  1  1 = CBC, 0 = ECB; latched per transaction
in_byte  in  8  input byte
in_valid  in  1  input byte valid
in_ready  out  1  controller accepts a byte (transfer = in_valid & in_ready)
out_byte  out  8  output byte
out_valid  out  1  output byte valid
out_ready  in  1  consumer accepts (transfer = out_valid & out_ready)
eng_start  out  1  one-cycle start pulse to cipher core
eng_decrypt  out  1  latched rw_mode
eng_din  out  W  block to core
eng_keys  out  NUM_KEYS*W  key k at bits [(k+1)*W-1 : k*W]
eng_dout  in  W  result from core
eng_done  in  1  one-cycle done pulse, eng_dout valid that cycle
keys_loaded  out  1  all NUM_KEYS keys captured this transaction
busy  out  1  high in CRYPT or EMIT

Behaviour:
- Reset: state LOAD_KEY, byte_cnt = 0, key_idx = 0, keys, IV, chain and shift registers = 0. Outputs: in_ready = 1, out_valid = 0, eng_start = 0, keys_loaded = 0, busy = 0, out_byte = 0.
- Byte packing: MSB first. The first accepted byte of a block lands in bits [W-1:W-8]. byte_cnt wraps 0..BLOCK_BYTES-1.
- rw_mode and cbc_en are sampled on the first key byte accepted in LOAD_KEY and held until the next stop or rst.
- LOAD_KEY (in_ready = 1):
  - Completed block is written to key[key_idx], then key_idx increments.
  - After key NUM_KEYS-1 is written, keys_loaded = 1.
  - Next state is LOAD_IV if cbc_en is latched, else COLLECT.
- LOAD_IV (in_ready = 1): completed block is written to the chain register; next state COLLECT.
- COLLECT (in_ready = 1): on the last byte of a block, the block is captured in blk_reg and the state moves to CRYPT. eng_start is asserted in the following cycle (last byte at T, eng_start at T+1).
- eng_din:
  - Encrypt + CBC: blk_reg XOR chain.
  - Decrypt + CBC: blk_reg.
  - ECB: blk_reg.
- CRYPT (in_ready = 0, busy = 1): waits for eng_done; no timeout. On eng_done (cycle D), the result is registered and the state moves to EMIT; out_valid = 1 at D+1.
  - Encrypt + CBC: result = eng_dout; chain <= eng_dout.
  - Decrypt + CBC: result = eng_dout XOR chain; chain <= blk_reg.
  - ECB: result = eng_dout.
- EMIT (busy = 1): the result is shifted out MSB byte first, one byte per out transfer. out_byte is stable while out_valid & !out_ready. After the BLOCK_BYTES-th transfer, out_valid drops in the next cycle and the state returns to COLLECT (in_ready = 1).
- eng_done outside CRYPT is ignored.
- stop handling:
  - In LOAD_KEY, LOAD_IV or COLLECT: partial block discarded, byte_cnt = key_idx = 0, keys_loaded = 0, next state LOAD_KEY. Stored keys and chain are kept but are overwritten by the next transaction.
  - In CRYPT or EMIT: sets stop_pend. The current block completes and fully drains, then the controller goes to LOAD_KEY instead of COLLECT.
  - Priority: stop beats a same-cycle in_valid byte, which is not accepted (in_ready is forced 0 that cycle).
- rst mid-operation: immediate return to the reset values above. A pending eng_done is ignored. Any partially emitted block is lost.
- Throughput: no overlap between collection and emission. Block period = BLOCK_BYTES input cycles + 1 + engine latency + 1 + BLOCK_BYTES output cycles (plus backpressure).

Test Plan:
- Bench core model: eng_dout = eng_din XOR key0, done 3 cycles after start. Defaults used, ECB, encrypt. Send key0 = 0x0123456789ABCDEF, key1 = any, data 0x1111111111111111 -> eng_start 1 cycle after last byte; eng_din = 0x1111111111111111; out bytes 0x10,0x32,0x54,0x76,0x98,0xBA,0xDC,0xFE.
- CBC encrypt then decrypt round trip, IV 0xA5A5A5A5A5A5A5A5, three data blocks -> second pass returns the original plaintexts exactly. Chain register equals the last ciphertext after each block.
- Hold out_ready = 0 for 10 cycles mid-EMIT -> out_byte stays constant and out_valid stays high; no byte is lost or duplicated; in_ready = 0 throughout.
- stop after 5 bytes of a data block -> next byte is treated as key byte 0; keys_loaded = 0 until 2 new key blocks arrive. stop with a same-cycle in_valid -> that byte is not accepted.
- stop during CRYPT -> all 8 bytes of the block are still emitted, then LOAD_KEY; with BLOCK_BYTES = 16 and NUM_KEYS = 3, eng_keys packs the keys at the correct offsets.
- Assert rst during EMIT at byte 3 -> next cycle out_valid = 0, in_ready = 1, busy = 0, keys_loaded = 0; an eng_done pulse afterwards is ignored.
